mem_port_arbiter: RTL and testbench

- Shares the single main-memory block port between the I-cache miss path and the D-cache miss/write-back path of the RISC-V core.
- Sits between both caches and data memory. Grants one whole block transaction at a time.
- Uses round-robin arbitration on simultaneous requests, so a store-heavy loop cannot starve instruction fetch.
- Keeps 16-bit saturating grant counters, used for cache-switching experiments.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the shared memory block port
// between the I-cache miss path and the D-cache miss/write-back path.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ic_read,
    input  logic [ADDR_WIDTH-1:0]  ic_address,
    output logic                   ic_busywait,
    output logic [BLOCK_WIDTH-1:0] ic_readdata,
    input  logic                   dc_read,
    input  logic                   dc_write,
    input  logic [ADDR_WIDTH-1:0]  dc_address,
    input  logic [BLOCK_WIDTH-1:0] dc_writedata,
    output logic                   dc_busywait,
    output logic [BLOCK_WIDTH-1:0] dc_readdata,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [BLOCK_WIDTH-1:0] mem_writedata,
    input  logic [BLOCK_WIDTH-1:0] mem_readdata,
    input  logic                   mem_busywait,
    output logic [15:0]            ic_grant_cnt,
    output logic [15:0]            dc_grant_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic        OWN_I   = 1'b0;
    localparam logic        OWN_D   = 1'b1;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t state_q, state_n;
    logic   owner_q, owner_n;
    logic   last_q, last_n;
    logic   wr_q, wr_n;
    logic   mem_rd_q, mem_rd_n;
    logic   mem_wr_q, mem_wr_n;

    logic [ADDR_WIDTH-1:0]  addr_q, addr_n;
    logic [BLOCK_WIDTH-1:0] wdata_q, wdata_n;
    logic [BLOCK_WIDTH-1:0] ic_rdata_q, ic_rdata_n;
    logic [BLOCK_WIDTH-1:0] dc_rdata_q, dc_rdata_n;
    logic [15:0]            ic_cnt_q, ic_cnt_n;
    logic [15:0]            dc_cnt_q, dc_cnt_n;

    logic ic_req;
    logic dc_req;
    logic grant_d;

    assign ic_req  = ic_read;
    assign dc_req  = dc_read | dc_write;
    // On a tie the side that did not finish last wins
    assign grant_d = dc_req & (~ic_req | (last_q == OWN_I));

    always_comb begin
        state_n    = state_q;
        owner_n    = owner_q;
        last_n     = last_q;
        wr_n       = wr_q;
        mem_rd_n   = mem_rd_q;
        mem_wr_n   = mem_wr_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        ic_rdata_n = ic_rdata_q;
        dc_rdata_n = dc_rdata_q;
        ic_cnt_n   = ic_cnt_q;
        dc_cnt_n   = dc_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ic_req | dc_req) begin
                    owner_n  = grant_d;
                    wr_n     = grant_d & dc_write;
                    mem_rd_n = ~(grant_d & dc_write);
                    mem_wr_n = grant_d & dc_write;
                    addr_n   = grant_d ? dc_address : ic_address;
                    if (grant_d) begin
                        wdata_n = dc_writedata;
                    end
                    state_n  = ISSUE;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (!mem_busywait) begin
                    mem_rd_n = 1'b0;
                    mem_wr_n = 1'b0;
                    last_n   = owner_q;
                    if (owner_q == OWN_D) begin
                        if (!wr_q) begin
                            dc_rdata_n = mem_readdata;
                        end
                        if (dc_cnt_q != CNT_MAX) begin
                            dc_cnt_n = dc_cnt_q + 16'd1;
                        end
                    end else begin
                        if (!wr_q) begin
                            ic_rdata_n = mem_readdata;
                        end
                        if (ic_cnt_q != CNT_MAX) begin
                            ic_cnt_n = ic_cnt_q + 16'd1;
                        end
                    end
                    state_n  = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            last_q     <= OWN_I;
            wr_q       <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
            ic_cnt_q   <= '0;
            dc_cnt_q   <= '0;
        end else begin
            state_q    <= state_n;
            owner_q    <= owner_n;
            last_q     <= last_n;
            wr_q       <= wr_n;
            mem_rd_q   <= mem_rd_n;
            mem_wr_q   <= mem_wr_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            ic_rdata_q <= ic_rdata_n;
            dc_rdata_q <= dc_rdata_n;
            ic_cnt_q   <= ic_cnt_n;
            dc_cnt_q   <= dc_cnt_n;
        end
    end

    assign ic_busywait = ic_req & ~((state_q == RESP) & (owner_q == OWN_I));
    assign dc_busywait = dc_req & ~((state_q == RESP) & (owner_q == OWN_D));

    assign mem_read      = mem_rd_q;
    assign mem_write     = mem_wr_q;
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign ic_readdata   = ic_rdata_q;
    assign dc_readdata   = dc_rdata_q;
    assign ic_grant_cnt  = ic_cnt_q;
    assign dc_grant_cnt  = dc_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions
// plus sequences for ties, round-robin, reset in flight and saturation.
module tb_mem_port_arbiter;

    logic         clk;
    logic         rst;
    logic         ic_read;
    logic [27:0]  ic_address;
    logic         ic_busywait;
    logic [127:0] ic_readdata;
    logic         dc_read;
    logic         dc_write;
    logic [27:0]  dc_address;
    logic [127:0] dc_writedata;
    logic         dc_busywait;
    logic [127:0] dc_readdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic [15:0]  ic_grant_cnt;
    logic [15:0]  dc_grant_cnt;

    int n_checks;
    int n_fail;

    mem_port_arbiter #(.ADDR_WIDTH(28), .BLOCK_WIDTH(128)) dut (
        .CLK(clk),
        .RESET(rst),
        .ic_read(ic_read),
        .ic_address(ic_address),
        .ic_busywait(ic_busywait),
        .ic_readdata(ic_readdata),
        .dc_read(dc_read),
        .dc_write(dc_write),
        .dc_address(dc_address),
        .dc_writedata(dc_writedata),
        .dc_busywait(dc_busywait),
        .dc_readdata(dc_readdata),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait),
        .ic_grant_cnt(ic_grant_cnt),
        .dc_grant_cnt(dc_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: busy rises the edge after a new strobe, stays high lat cycles
    int           lat;
    int           mem_cnt;
    logic         mem_busy;
    logic         strobe_q;
    logic [127:0] mem_data;

    assign mem_busywait = mem_busy;
    assign mem_readdata = mem_busy ? 128'h0 : mem_data;

    always @(posedge clk) begin
        if (rst) begin
            mem_busy <= 1'b0;
            strobe_q <= 1'b0;
            mem_cnt  <= 0;
        end else begin
            strobe_q <= mem_read | mem_write;
            if (mem_busy) begin
                if (mem_cnt <= 1) mem_busy <= 1'b0;
                else mem_cnt <= mem_cnt - 1;
            end else if ((mem_read | mem_write) && !strobe_q) begin
                mem_busy <= 1'b1;
                mem_cnt  <= lat;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ic_read  = 1'b0;
        dc_read  = 1'b0;
        dc_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction from an idle arbiter; returns at the idle negedge
    task automatic txn(input logic ic, input logic dr, input logic dw,
                       output int strobes, output int first,
                       output logic [27:0] addr0, output logic [127:0] wd0,
                       output logic rd0, output logic wr0,
                       output logic stable);
        logic done;
        done     = 1'b0;
        strobes  = 0;
        first    = -1;
        addr0    = '0;
        wd0      = '0;
        rd0      = 1'b0;
        wr0      = 1'b0;
        stable   = 1'b1;
        ic_read  = ic;
        dc_read  = dr;
        dc_write = dw;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (mem_read | mem_write) begin
                strobes++;
                if (first < 0) begin
                    first = c;
                    addr0 = mem_address;
                    wd0   = mem_writedata;
                    rd0   = mem_read;
                    wr0   = mem_write;
                end else if (mem_address !== addr0) begin
                    stable = 1'b0;
                end
            end
            if (c == 1) begin
                ic_address   = ~ic_address;
                dc_address   = ~dc_address;
                dc_writedata = ~dc_writedata;
            end
            if (ic ? !ic_busywait : !dc_busywait) done = 1'b1;
        end
        check("txn_done", 128'(done), 128'(1));
        ic_read  = 1'b0;
        dc_read  = 1'b0;
        dc_write = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic         ic;
        logic         dr;
        logic         dw;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int           lat;
        logic         wr;
        logic [127:0] ic_rd;
        logic [127:0] dc_rd;
        logic [15:0]  ic_c;
        logic [15:0]  dc_c;
    } vec_t;

    localparam logic [127:0] D0 = 128'h0123456789ABCDEF_00000000_DEADBEEF;
    localparam logic [127:0] D1 = 128'hCAFEF00D_11112222_33334444_55556666;
    localparam logic [127:0] D4 = 128'h89ABCDEF_76543210_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] A5 = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam logic [127:0] P5A = 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A;

    vec_t         vt[5];
    int           strobes;
    int           first;
    logic [27:0]  addr0;
    logic [127:0] wd0;
    logic         rd0;
    logic         wr0;
    logic         stable;
    int           overlap;
    int           d_at;
    int           i_at;
    logic [15:0]  ic_at_d;
    logic [5:0]   pat;
    int           ng;
    logic         prev;
    logic         fin;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        lat          = 1;
        mem_data     = '0;
        ic_address   = '0;
        dc_address   = '0;
        dc_writedata = '0;

        vt[0] = '{1'b1, 1'b0, 1'b0, 28'h0000010, 128'h0, D0, 3, 1'b0,
                  D0, 128'h0, 16'd1, 16'd0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 28'h1234567, 128'h0, D1, 1, 1'b0,
                  D0, D1, 16'd1, 16'd1};
        vt[2] = '{1'b0, 1'b1, 1'b1, 28'h0ABCDEF, A5, ~D1, 2, 1'b1,
                  D0, D1, 16'd1, 16'd2};
        vt[3] = '{1'b0, 1'b0, 1'b1, 28'hFFFFFFF, P5A, 128'h1, 4, 1'b1,
                  D0, D1, 16'd1, 16'd3};
        vt[4] = '{1'b1, 1'b0, 1'b0, 28'h0000000, 128'h0, D4, 2, 1'b0,
                  D4, D1, 16'd2, 16'd3};

        do_reset();
        check("rst_mem_read", 128'(mem_read), 128'(0));
        check("rst_mem_write", 128'(mem_write), 128'(0));
        check("rst_mem_address", 128'(mem_address), 128'(0));
        check("rst_mem_writedata", mem_writedata, 128'h0);
        check("rst_ic_readdata", ic_readdata, 128'h0);
        check("rst_dc_readdata", dc_readdata, 128'h0);
        check("rst_ic_cnt", 128'(ic_grant_cnt), 128'(0));
        check("rst_dc_cnt", 128'(dc_grant_cnt), 128'(0));
        check("rst_ic_busywait", 128'(ic_busywait), 128'(0));
        check("rst_dc_busywait", 128'(dc_busywait), 128'(0));

        for (int i = 0; i < 5; i++) begin
            lat          = vt[i].lat;
            mem_data     = vt[i].rdata;
            ic_address   = vt[i].ic ? vt[i].addr : ~vt[i].addr;
            dc_address   = vt[i].ic ? ~vt[i].addr : vt[i].addr;
            dc_writedata = vt[i].wdata;
            txn(vt[i].ic, vt[i].dr, vt[i].dw, strobes, first, addr0, wd0,
                rd0, wr0, stable);
            check($sformatf("v%0d_first_strobe", i), 128'(first), 128'(1));
            check($sformatf("v%0d_strobe_cycles", i), 128'(strobes),
                  128'(vt[i].lat + 2));
            check($sformatf("v%0d_mem_read", i), 128'(rd0), 128'(!vt[i].wr));
            check($sformatf("v%0d_mem_write", i), 128'(wr0), 128'(vt[i].wr));
            check($sformatf("v%0d_mem_address", i), 128'(addr0),
                  128'(vt[i].addr));
            check($sformatf("v%0d_addr_stable", i), 128'(stable), 128'(1));
            if (vt[i].wr)
                check($sformatf("v%0d_mem_writedata", i), wd0, vt[i].wdata);
            check($sformatf("v%0d_ic_readdata", i), ic_readdata, vt[i].ic_rd);
            check($sformatf("v%0d_dc_readdata", i), dc_readdata, vt[i].dc_rd);
            check($sformatf("v%0d_ic_cnt", i), 128'(ic_grant_cnt),
                  128'(vt[i].ic_c));
            check($sformatf("v%0d_dc_cnt", i), 128'(dc_grant_cnt),
                  128'(vt[i].dc_c));
        end

        // Simultaneous request after reset: D first, then I
        do_reset();
        lat        = 2;
        mem_data   = D1;
        ic_address = 28'h0000111;
        dc_address = 28'h0000222;
        ic_read    = 1'b1;
        dc_read    = 1'b1;
        overlap    = 0;
        d_at       = 0;
        i_at       = 0;
        ic_at_d    = 16'hDEAD;
        addr0      = '0;
        first      = -1;
        for (int c = 1; c <= 100 && (d_at == 0 || i_at == 0); c++) begin
            @(negedge clk);
            if (mem_read && mem_write) overlap++;
            if ((mem_read | mem_write) && first < 0) begin
                first = c;
                addr0 = mem_address;
            end
            if (dc_read && !dc_busywait) begin
                d_at    = c;
                ic_at_d = ic_grant_cnt;
                dc_read = 1'b0;
            end
            if (ic_read && !ic_busywait) begin
                i_at    = c;
                ic_read = 1'b0;
            end
        end
        ic_read = 1'b0;
        dc_read = 1'b0;
        @(negedge clk);
        check("tie_first_addr", 128'(addr0), 128'(28'h0000222));
        check("tie_d_before_i", 128'(d_at > 0 && d_at < i_at), 128'(1));
        check("tie_ic_cnt_at_d", 128'(ic_at_d), 128'(0));
        check("tie_dc_cnt", 128'(dc_grant_cnt), 128'(1));
        check("tie_ic_cnt", 128'(ic_grant_cnt), 128'(1));
        check("tie_no_overlap", 128'(overlap), 128'(0));

        // Both sides hold requests: strict alternation from D
        do_reset();
        lat     = 1;
        ic_read = 1'b1;
        dc_read = 1'b1;
        ng      = 0;
        prev    = 1'b0;
        pat     = '0;
        overlap = 0;
        fin     = 1'b0;
        for (int c = 1; c <= 300 && !fin; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) overlap++;
            if ((mem_read | mem_write) && !prev && ng < 6) begin
                pat[ng] = (mem_address == 28'h0000222);
                ng++;
            end
            prev = mem_read | mem_write;
            if (ng == 6 && !ic_busywait) fin = 1'b1;
        end
        ic_read = 1'b0;
        dc_read = 1'b0;
        @(negedge clk);
        check("rr_done", 128'(fin), 128'(1));
        check("rr_order", 128'(pat), 128'(6'b010101));
        check("rr_ic_cnt", 128'(ic_grant_cnt), 128'(3));
        check("rr_dc_cnt", 128'(dc_grant_cnt), 128'(3));
        check("rr_no_overlap", 128'(overlap), 128'(0));

        // Reset while waiting on memory, request kept high throughout
        do_reset();
        lat        = 10;
        mem_data   = D4;
        ic_address = 28'h0000333;
        ic_read    = 1'b1;
        repeat (4) @(negedge clk);
        check("rw_strobe_before", 128'(mem_read), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        check("rw_mem_read_drop", 128'(mem_read), 128'(0));
        check("rw_ic_cnt", 128'(ic_grant_cnt), 128'(0));
        check("rw_ic_busywait", 128'(ic_busywait), 128'(1));
        rst = 1'b0;
        lat = 2;
        @(negedge clk);
        check("rw_regrant", 128'(mem_read), 128'(1));
        check("rw_regrant_addr", 128'(mem_address), 128'(28'h0000333));
        fin = 1'b0;
        for (int c = 1; c <= 100 && !fin; c++) begin
            @(negedge clk);
            if (!ic_busywait) fin = 1'b1;
        end
        check("rw_done", 128'(fin), 128'(1));
        check("rw_ic_readdata", ic_readdata, D4);
        ic_read = 1'b0;
        @(negedge clk);
        check("rw_ic_cnt_after", 128'(ic_grant_cnt), 128'(1));

        // Saturation: preload the D counter one below the limit
        do_reset();
        force dut.dc_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.dc_cnt_q;
        lat          = 1;
        mem_data     = D0;
        dc_address   = 28'h0000444;
        txn(1'b0, 1'b1, 1'b0, strobes, first, addr0, wd0, rd0, wr0, stable);
        check("sat_reach_max", 128'(dc_grant_cnt), 128'(16'hFFFF));
        check("sat_readdata", dc_readdata, D0);
        dc_address = 28'h0000555;
        txn(1'b0, 1'b1, 1'b0, strobes, first, addr0, wd0, rd0, wr0, stable);
        check("sat_hold_max", 128'(dc_grant_cnt), 128'(16'hFFFF));
        check("sat_ic_cnt", 128'(ic_grant_cnt), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
